// File: rtl/ram_arbiter.sv
// Round-robin burst arbiter sharing one RAM port between two cache masters, with a hold watchdog.
// Optional per-master grant/wait counters are compiled in with `define ARB_STATS_EN.
module ram_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 13,
  parameter int MAX_HOLD   = 80,
  parameter int HOLD_LEN   = $clog2(MAX_HOLD+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
`ifdef ARB_STATS_EN
  output logic [15:0]           stat_gnt0,
  output logic [15:0]           stat_gnt1,
  output logic [15:0]           stat_wait0,
  output logic [15:0]           stat_wait1,
`endif
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state;
  logic                last_owner;
  logic [HOLD_LEN-1:0] hold_cnt;
  logic [1:0]          rvalid_q;
  logic                cur, cur_req, oth_req;

  assign m0_gnt    = (state == OWN0);
  assign m1_gnt    = (state == OWN1);
  assign cur       = (state == OWN1);
  assign cur_req   = cur ? m1_req : m0_req;
  assign oth_req   = cur ? m0_req : m1_req;
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rvalid_q[0] ? ram_data_out : '0;
  assign m1_rdata  = rvalid_q[1] ? ram_data_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      rvalid_q   <= '0;
      err        <= 1'b0;
    end else begin
      rvalid_q <= {m1_gnt & ram_read, m0_gnt & ram_read};
      case (state)
        IDLE: begin
          if (m0_req && (!m1_req || last_owner)) begin
            state      <= OWN0;
            last_owner <= 1'b0;
            hold_cnt   <= '0;
          end else if (m1_req) begin
            state      <= OWN1;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
          end
        end
        OWN0, OWN1: begin
          if (cur_req && hold_cnt < HOLD_LEN'(MAX_HOLD-1)) begin
            hold_cnt <= hold_cnt + HOLD_LEN'(1);
          end else begin
            // Reaching here with req still high means the watchdog fired.
            if (cur_req) err <= 1'b1;
            if (oth_req) begin
              state      <= cur ? OWN0 : OWN1;
              last_owner <= ~cur;
              hold_cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr    = '0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_data_in = '0;
    if (m0_gnt) begin
      ram_addr    = m0_addr;
      ram_data_in = m0_wdata;
      ram_write   = m0_write;
      ram_read    = m0_read & ~m0_write;
    end else if (m1_gnt) begin
      ram_addr    = m1_addr;
      ram_data_in = m1_wdata;
      ram_write   = m1_write;
      ram_read    = m1_read & ~m1_write;
    end
  end

`ifdef ARB_STATS_EN
  logic gnt0_q, gnt1_q;

  // Grant entries are counted on the rising edge of each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      stat_gnt0  <= '0;
      stat_gnt1  <= '0;
      stat_wait0 <= '0;
      stat_wait1 <= '0;
    end else begin
      gnt0_q <= m0_gnt;
      gnt1_q <= m1_gnt;
      if (m0_gnt && !gnt0_q && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
      if (m1_gnt && !gnt1_q && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
      if (m0_req && !m0_gnt && stat_wait0 != 16'hFFFF) stat_wait0 <= stat_wait0 + 16'd1;
      if (m1_req && !m1_gnt && stat_wait1 != 16'hFFFF) stat_wait1 <= stat_wait1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, reads, fair handoff, write priority, watchdog, mid-burst reset.
module tb_ram_arbiter;
  localparam int DW = 10;
  localparam int AW = 13;
  localparam int MH = 80;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_read, m0_write, m1_req, m1_read, m1_write;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_data_in, ram_data_out;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_read, ram_write, err;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_gnt0, stat_gnt1, stat_wait0, stat_wait1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
`ifdef ARB_STATS_EN
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_wait0(stat_wait0), .stat_wait1(stat_wait1),
`endif
    .err(err)
  );

  // RAM model: read data is 0x3A0 + addr, one cycle after the strobe.
  always @(posedge clk)
    ram_data_out <= ram_read ? (10'h3A0 + ram_addr[DW-1:0]) : 10'h000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_read = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_read = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_ram_read", ram_read, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_err", err, 0);
    check("rst_m0_rdata", m0_rdata, 0);

    // m0 alone: four reads
    m0_req = 1;
    #1 check("m0_gnt_before_edge", m0_gnt, 0);
    step();
    check("m0_gnt_cycle1", m0_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      m0_read = 1; m0_addr = AW'(13'h020 + i);
      #1 check("rd_ram_addr", ram_addr, 32'h020 + i);
      check("rd_ram_read", ram_read, 1);
      step();
      check("rd_m0_rvalid", m0_rvalid, 1);
      check("rd_m0_rdata", m0_rdata, 32'h3C0 + i);
      check("rd_m1_rvalid", m1_rvalid, 0);
    end
    m0_read = 0;
    step();
    check("rd_rvalid_drop", m0_rvalid, 0);
    m0_req = 0;
    step();
    check("m0_release", m0_gnt, 0);

    // simultaneous request after reset: m0 wins, then direct handoff
    do_reset();
    m0_req = 1; m1_req = 1;
    m1_write = 1; m1_addr = 13'h1FF;
    step();
    check("tie_m0_gnt", m0_gnt, 1);
    check("tie_m1_gnt", m1_gnt, 0);
    for (int i = 0; i < 32; i++) begin
      m0_write = 1; m0_addr = AW'(13'h040 + i); m0_wdata = DW'(i);
      #1;
      if (i == 5) begin
        check("burst_ram_addr", ram_addr, 32'h045);
        check("burst_ram_din", ram_data_in, 5);
        check("burst_m1_gnt", m1_gnt, 0);
      end
      step();
    end
    m0_req = 0; m0_write = 0; m1_write = 0;
    step();
    check("handoff_m1_gnt", m1_gnt, 1);
    check("handoff_m0_gnt", m0_gnt, 0);

    // write wins over read
    m1_read = 1; m1_write = 1; m1_addr = 13'h100; m1_wdata = 10'h155;
    #1 check("wr_ram_write", ram_write, 1);
    check("wr_ram_read", ram_read, 0);
    check("wr_ram_din", ram_data_in, 32'h155);
    check("wr_ram_addr", ram_addr, 32'h100);
    step();
    check("wr_m1_rvalid", m1_rvalid, 0);
    m1_req = 0; m1_read = 0; m1_write = 0;
    step();
    check("m1_release", m1_gnt, 0);

    // re-request together: last_owner=1 so m0 wins; then m0 hogs into the watchdog
    m0_req = 1; m1_req = 1;
    step();
    check("rr_m0_gnt", m0_gnt, 1);
    check("rr_m1_gnt", m1_gnt, 0);
    for (int k = 1; k < MH; k++) step();
    check("hold_m0_gnt", m0_gnt, 1);
    check("hold_err", err, 0);
    step();
    check("revoke_m0_gnt", m0_gnt, 0);
    check("revoke_m1_gnt", m1_gnt, 1);
    check("revoke_err", err, 1);
    m0_req = 0;
    step();
    step();
    check("err_sticky", err, 1);
    check("m1_still_owner", m1_gnt, 1);

    // reset mid-burst with a read outstanding
    m1_read = 1; m1_addr = 13'h005;
    step();
    check("pre_rst_m1_rvalid", m1_rvalid, 1);
    check("pre_rst_m1_rdata", m1_rdata, 32'h3A5);
    rst = 1;
    step();
    check("mid_rst_m1_gnt", m1_gnt, 0);
    check("mid_rst_m1_rvalid", m1_rvalid, 0);
    check("mid_rst_m1_rdata", m1_rdata, 0);
    check("mid_rst_ram_read", ram_read, 0);
    check("mid_rst_err", err, 0);
`ifdef ARB_STATS_EN
    check("stat_gnt0", stat_gnt0, 0);
    check("stat_gnt1", stat_gnt1, 0);
    check("stat_wait0", stat_wait0, 0);
    check("stat_wait1", stat_wait1, 0);
`endif
    rst = 0;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
